// File: rtl/cpu_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter_if
// Bundles the CPU-side fetch and data ports and the memory-side bus of the
// instruction/data memory arbiter.
//   i_*  : instruction-fetch port (request/address in, ready/read data out)
//   d_*  : load/store data port (request/address/write data/strobes in,
//          ready/read data out)
//   m_*  : shared memory bus (request/address/write data/strobes out,
//          ready/read data in)
// Modports:
//   slave  : the arbiter's view (requests in from the core, bus out to memory)
//   master : the environment's view (core + memory model driving the arbiter)
// ---------------------------------------------------------------------------
interface cpu_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Fetch port
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_rdata;

  // Data port
  logic                  d_req;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [STRB_WIDTH-1:0] d_wstrb;
  logic                  d_ready;
  logic [DATA_WIDTH-1:0] d_rdata;

  // Memory bus
  logic                  m_req;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [STRB_WIDTH-1:0] m_wstrb;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_ready, i_rdata,
    input  d_req, d_addr, d_wdata, d_wstrb,
    output d_ready, d_rdata,
    output m_req, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ready, i_rdata,
    output d_req, d_addr, d_wdata, d_wstrb,
    input  d_ready, d_rdata,
    input  m_req, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rdata
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter
// Shares one memory bus between the instruction-fetch port and the load/store
// data port. In IDLE the winning request is registered onto the bus; the
// arbiter then holds the bus until memory acknowledges and routes the
// response back to the owner. Data normally wins a contested cycle, but after
// MAX_DATA_STREAK consecutive contested data grants the fetch port is forced
// through so it can never starve.
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   bus  : cpu_mem_arbiter_if.slave (fetch port, data port, memory bus)
//   busy : high whenever a transaction owns the bus (state != IDLE)
// ---------------------------------------------------------------------------
module cpu_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  cpu_mem_arbiter_if.slave       bus,
  output logic                   busy
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  state_e                state_q,   state_d;
  logic [STREAK_W-1:0]   streak_q,  streak_d;
  logic                  m_req_q,   m_req_d;
  logic [ADDR_WIDTH-1:0] m_addr_q,  m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [STRB_WIDTH-1:0] m_wstrb_q, m_wstrb_d;

  logic                  grant_i_s;
  logic                  grant_d_s;

  // Arbitration decision, only meaningful while IDLE. Fetch wins when it is
  // alone or when the data streak has reached its limit.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_q == IDLE) begin
      grant_i_s = bus.i_req && (!bus.d_req || (streak_q == STREAK_MAX));
      grant_d_s = bus.d_req && !grant_i_s;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // State register and bus/streak flops, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      streak_q  <= {STREAK_W{1'b0}};
      m_req_q   <= 1'b0;
      m_addr_q  <= {ADDR_WIDTH{1'b0}};
      m_wdata_q <= {DATA_WIDTH{1'b0}};
      m_wstrb_q <= {STRB_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      m_req_q   <= m_req_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_i_s) begin
          state_d = GRANT_I;
        end else if (grant_d_s) begin
          state_d = GRANT_D;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        if (bus.m_ready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered bus signals and the data streak counter.
  // Requester inputs are only sampled in IDLE; the bus holds during a grant.
  always_comb begin
    streak_d  = streak_q;
    m_req_d   = m_req_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    case (state_q)
      IDLE: begin
        if (grant_i_s) begin
          m_req_d   = 1'b1;
          m_addr_d  = bus.i_addr;
          m_wdata_d = {DATA_WIDTH{1'b0}};
          m_wstrb_d = {STRB_WIDTH{1'b0}};
          streak_d  = {STREAK_W{1'b0}};
        end else if (grant_d_s) begin
          m_req_d   = 1'b1;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          m_wstrb_d = bus.d_wstrb;
          // Only a contested data grant extends the streak.
          if (bus.i_req) begin
            if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + {{(STREAK_W-1){1'b0}}, 1'b1};
            end else begin
              streak_d = streak_q;
            end
          end else begin
            streak_d = {STREAK_W{1'b0}};
          end
        end else begin
          m_req_d = 1'b0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (bus.m_ready) begin
          m_req_d = 1'b0;
        end else begin
          m_req_d = 1'b1;
        end
      end
      default: begin
        m_req_d = 1'b0;
      end
    endcase
  end

  // Outputs: ready pulses are combinational from m_ready, gated by the
  // owning grant state so a spurious m_ready in IDLE is ignored.
  always_comb begin
    bus.i_ready = (state_q == GRANT_I) && bus.m_ready;
    bus.d_ready = (state_q == GRANT_D) && bus.m_ready;
    bus.i_rdata = bus.m_rdata;
    bus.d_rdata = bus.m_rdata;
    bus.m_req   = m_req_q;
    bus.m_addr  = m_addr_q;
    bus.m_wdata = m_wdata_q;
    bus.m_wstrb = m_wstrb_q;
    busy        = (state_q != IDLE);
  end

endmodule
